// File: rtl/snake_datapath.sv
// Snake game datapath: segment storage, movement, fruit placement,
// collision detection and registered VGA plot muxing.
module snake_datapath #(
  parameter int MAX_LEN  = 100,
  parameter int INIT_LEN = 4
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       move,
  input  logic       keyboard,
  input  logic [1:0] keyboard_arrow,
  input  logic       output_signal,
  input  logic [3:0] select,
  input  logic [7:0] counter_x,
  input  logic [6:0] counter_y,
  input  logic [6:0] counter_j,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       endgame
);

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    LEFT  = 2'd2,
    DOWN  = 2'd3
  } dir_e;

  localparam logic [6:0] MAXL  = 7'(MAX_LEN);
  localparam logic [6:0] INITL = 7'(INIT_LEN);

  logic [7:0]  seg_x_q [MAX_LEN];
  logic [7:0]  seg_x_d [MAX_LEN];
  logic [6:0]  seg_y_q [MAX_LEN];
  logic [6:0]  seg_y_d [MAX_LEN];
  logic [6:0]  len_q, len_d;
  dir_e        dir_q, dir_d;
  dir_e        pend_q, pend_d;
  dir_e        key_ref;
  logic [7:0]  fruit_x_q, fruit_x_d;
  logic [6:0]  fruit_y_q, fruit_y_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [2:0]  colour_q, colour_d;
  logic        plot_q, plot_d;
  logic        endgame_q, endgame_d;

  logic [7:0] hx, nx, cand_x;
  logic [6:0] hy, ny, cand_y;
  logic [6:0] idx;
  logic       wall, idx_ok, collide, over, eat;

  function automatic logic [7:0] init_x(int k);
    return (k < INIT_LEN) ? 8'(80 - k) : 8'd0;
  endfunction

  function automatic logic [6:0] init_y(int k);
    return (k < INIT_LEN) ? 7'd60 : 7'd0;
  endfunction

  assign hx  = seg_x_q[0];
  assign hy  = seg_y_q[0];
  assign idx = 7'd99 - counter_j;

  assign lfsr_d = {lfsr_q[14:0],
                   lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  assign cand_x = (lfsr_q[7:0] >= 8'd160)
                ? lfsr_q[7:0] - 8'd128 : lfsr_q[7:0];
  assign cand_y = (lfsr_q[14:8] >= 7'd120)
                ? lfsr_q[14:8] - 7'd64 : lfsr_q[14:8];

  always_comb begin
    nx   = hx;
    ny   = hy;
    wall = 1'b0;
    unique case (pend_q)
      UP: begin
        wall = (hy == 7'd0);
        ny   = hy - 7'd1;
      end
      DOWN: begin
        wall = (hy == 7'd119);
        ny   = hy + 7'd1;
      end
      LEFT: begin
        wall = (hx == 8'd0);
        nx   = hx - 8'd1;
      end
      RIGHT: begin
        wall = (hx == 8'd159);
        nx   = hx + 8'd1;
      end
    endcase
  end

  assign idx_ok  = (counter_j <= 7'd99) && (idx < len_q);
  // Body-vs-head test rides on the draw pass so it costs one comparator.
  assign collide = output_signal && (select == 4'd0) && idx_ok
                && (idx != 7'd0)
                && (seg_x_q[idx] == hx) && (seg_y_q[idx] == hy);
  assign over    = (move && wall) || collide;
  assign eat     = move && !wall
                && (nx == fruit_x_q) && (ny == fruit_y_q);
  assign key_ref = move ? pend_q : dir_q;

  always_comb begin
    seg_x_d   = seg_x_q;
    seg_y_d   = seg_y_q;
    len_d     = len_q;
    dir_d     = dir_q;
    pend_d    = pend_q;
    fruit_x_d = fruit_x_q;
    fruit_y_d = fruit_y_q;
    if (over) begin
      for (int k = 0; k < MAX_LEN; k++) begin
        seg_x_d[k] = init_x(k);
        seg_y_d[k] = init_y(k);
      end
      len_d     = INITL;
      dir_d     = RIGHT;
      pend_d    = RIGHT;
      fruit_x_d = 8'd120;
      fruit_y_d = 7'd60;
    end else begin
      if (move) begin
        dir_d = pend_q;
        for (int i = 1; i < MAX_LEN; i++) begin
          seg_x_d[i] = seg_x_q[i-1];
          seg_y_d[i] = seg_y_q[i-1];
        end
        seg_x_d[0] = nx;
        seg_y_d[0] = ny;
        if (eat) begin
          if (len_q < MAXL) len_d = len_q + 7'd1;
          fruit_x_d = cand_x;
          fruit_y_d = cand_y;
        end
      end
      if (keyboard && ((keyboard_arrow ^ key_ref) != 2'd3))
        pend_d = dir_e'(keyboard_arrow);
    end
  end

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    colour_d  = colour_q;
    plot_d    = 1'b0;
    endgame_d = over;
    if (output_signal) begin
      case (select)
        4'd0: if (idx_ok) begin
          x_d      = seg_x_q[idx];
          y_d      = seg_y_q[idx];
          colour_d = (idx == 7'd0) ? 3'b110 : 3'b010;
          plot_d   = 1'b1;
        end
        4'd1: begin
          x_d      = counter_x;
          y_d      = counter_y;
          colour_d = 3'b000;
          plot_d   = 1'b1;
        end
        4'd2: begin
          x_d      = fruit_x_q;
          y_d      = fruit_y_q;
          colour_d = 3'b100;
          plot_d   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int k = 0; k < MAX_LEN; k++) begin
        seg_x_q[k] <= init_x(k);
        seg_y_q[k] <= init_y(k);
      end
      len_q     <= INITL;
      dir_q     <= RIGHT;
      pend_q    <= RIGHT;
      fruit_x_q <= 8'd120;
      fruit_y_q <= 7'd60;
      lfsr_q    <= 16'hACE1;
      x_q       <= '0;
      y_q       <= '0;
      colour_q  <= '0;
      plot_q    <= 1'b0;
      endgame_q <= 1'b0;
    end else begin
      seg_x_q   <= seg_x_d;
      seg_y_q   <= seg_y_d;
      len_q     <= len_d;
      dir_q     <= dir_d;
      pend_q    <= pend_d;
      fruit_x_q <= fruit_x_d;
      fruit_y_q <= fruit_y_d;
      lfsr_q    <= lfsr_d;
      x_q       <= x_d;
      y_q       <= y_d;
      colour_q  <= colour_d;
      plot_q    <= plot_d;
      endgame_q <= endgame_d;
    end
  end

  assign x       = x_q;
  assign y       = y_q;
  assign colour  = colour_q;
  assign plot    = plot_q;
  assign endgame = endgame_q;

endmodule

// File: tb/tb_snake_datapath.sv
// Self-checking bench for snake_datapath: vector table, directed
// game sequences and a randomized run against a queue-based model.
module tb_snake_datapath;

  localparam int MAXL = 100;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       move = 1'b0;
  logic       keyboard = 1'b0;
  logic [1:0] keyboard_arrow = '0;
  logic       output_signal = 1'b0;
  logic [3:0] select = '0;
  logic [7:0] counter_x = '0;
  logic [6:0] counter_y = '0;
  logic [6:0] counter_j = '0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       endgame;

  always #5 clock = ~clock;

  snake_datapath dut (
    .clock          (clock),
    .resetn         (resetn),
    .move           (move),
    .keyboard       (keyboard),
    .keyboard_arrow (keyboard_arrow),
    .output_signal  (output_signal),
    .select         (select),
    .counter_x      (counter_x),
    .counter_y      (counter_y),
    .counter_j      (counter_j),
    .x              (x),
    .y              (y),
    .colour         (colour),
    .plot           (plot),
    .endgame        (endgame)
  );

  // Model: snake body as a queue, head at front, size == length.
  int qx[$];
  int qy[$];
  int mdir, mpend, mfx, mfy;
  logic [15:0] mlfsr;
  int ex, ey, ec, ep, ee;
  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    bit   os;
    int   sel;
    int   cx;
    int   cy;
    int   cj;
    bit   care;
    int   x;
    int   y;
    int   c;
    int   p;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string nm, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", nm, got, want);
  endtask

  task automatic cmp_model();
    n_total++;
    if (x == ex && y == ey && colour == ec && plot == ep && endgame == ee)
      n_pass++;
    else
      $display("FAIL model @%0t: got x=%0d y=%0d c=%0d p=%0d e=%0d, want x=%0d y=%0d c=%0d p=%0d e=%0d",
               $time, x, y, colour, plot, endgame, ex, ey, ec, ep, ee);
  endtask

  task automatic model_init();
    qx.delete();
    qy.delete();
    for (int k = 0; k < 4; k++) begin
      qx.push_back(80 - k);
      qy.push_back(60);
    end
    mdir  = 1;
    mpend = 1;
    mfx   = 120;
    mfy   = 60;
  endtask

  task automatic model_step(input bit mv, input bit kb, input int ar,
                            input bit os, input int sl, input int cx,
                            input int cy, input int cj);
    int idx, hx, hy, nx, ny, refd, fx, fy;
    bit over;
    idx  = 99 - cj;
    hx   = qx[0];
    hy   = qy[0];
    over = 0;
    ep   = 0;
    if (os) begin
      if (sl == 1) begin
        ex = cx; ey = cy; ec = 0; ep = 1;
      end else if (sl == 2) begin
        ex = mfx; ey = mfy; ec = 4; ep = 1;
      end else if (sl == 0 && idx >= 0 && idx < qx.size()) begin
        ex = qx[idx]; ey = qy[idx]; ec = (idx == 0) ? 6 : 2; ep = 1;
        if (idx > 0 && qx[idx] == hx && qy[idx] == hy) over = 1;
      end
    end
    nx = hx;
    ny = hy;
    case (mpend)
      0: ny = ny - 1;
      1: nx = nx + 1;
      2: nx = nx - 1;
      default: ny = ny + 1;
    endcase
    if (mv && (nx < 0 || nx > 159 || ny < 0 || ny > 119)) over = 1;
    if (over) model_init();
    else begin
      refd = mv ? mpend : mdir;
      if (mv) begin
        mdir = mpend;
        qx.push_front(nx);
        qy.push_front(ny);
        if (nx == mfx && ny == mfy) begin
          if (qx.size() > MAXL) begin
            void'(qx.pop_back());
            void'(qy.pop_back());
          end
          fx = int'(mlfsr[7:0]);
          if (fx >= 160) fx = fx - 128;
          fy = int'(mlfsr[14:8]);
          if (fy >= 120) fy = fy - 64;
          mfx = fx;
          mfy = fy;
        end else begin
          void'(qx.pop_back());
          void'(qy.pop_back());
        end
      end
      if (kb && ((ar ^ refd) != 3)) mpend = ar;
    end
    ee    = over;
    mlfsr = {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
  endtask

  task automatic cyc(input bit mv, input bit kb, input int ar,
                     input bit os, input int sl, input int cx,
                     input int cy, input int cj);
    move           = mv;
    keyboard       = kb;
    keyboard_arrow = 2'(ar);
    output_signal  = os;
    select         = 4'(sl);
    counter_x      = 8'(cx);
    counter_y      = 7'(cy);
    counter_j      = 7'(cj);
    model_step(mv, kb, ar, os, sl, cx, cy, cj);
    @(posedge clock);
    #1;
    cmp_model();
  endtask

  task automatic do_reset(input bit mv);
    resetn        = 1'b0;
    move          = mv;
    keyboard      = 1'b0;
    output_signal = 1'b1;
    select        = 4'd0;
    counter_j     = 7'd99;
    @(posedge clock);
    #1;
    model_init();
    mlfsr = 16'hACE1;
    ex = 0; ey = 0; ec = 0; ep = 0; ee = 0;
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_colour", colour, 0);
    check("rst_plot", plot, 0);
    check("rst_endgame", endgame, 0);
    resetn = 1'b1;
    move   = 1'b0;
  endtask

  task automatic rd(input int idx);
    cyc(0, 0, 0, 1, 0, 0, 0, 99 - idx);
  endtask

  task automatic mv(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic key(input int ar);
    cyc(0, 1, ar, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int pcnt, egc, r, sl;
    tbl[0] = '{1, 2, 0, 0, 0, 1, 120, 60, 4, 1};
    tbl[1] = '{1, 1, 7, 9, 0, 1, 7, 9, 0, 1};
    tbl[2] = '{1, 1, 159, 119, 0, 1, 159, 119, 0, 1};
    tbl[3] = '{1, 0, 0, 0, 99, 1, 80, 60, 6, 1};
    tbl[4] = '{1, 0, 0, 0, 96, 1, 77, 60, 2, 1};
    tbl[5] = '{1, 3, 0, 0, 0, 1, 77, 60, 2, 0};
    tbl[6] = '{1, 15, 0, 0, 0, 1, 77, 60, 2, 0};
    tbl[7] = '{0, 2, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[8] = '{1, 0, 0, 0, 95, 0, 0, 0, 0, 0};
    tbl[9] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    do_reset(0);

    foreach (tbl[i]) begin
      cyc(0, 0, 0, tbl[i].os, tbl[i].sel, tbl[i].cx, tbl[i].cy, tbl[i].cj);
      check("tbl_plot", plot, tbl[i].p);
      if (tbl[i].care) begin
        check("tbl_x", x, tbl[i].x);
        check("tbl_y", y, tbl[i].y);
        check("tbl_colour", colour, tbl[i].c);
      end
    end

    // Full draw pass with the initial length of four.
    pcnt = 0;
    for (int j = 99; j >= 0; j--) begin
      cyc(0, 0, 0, 1, 0, 0, 0, j);
      if (plot) pcnt++;
      if (j == 99) begin
        check("draw_first_x", x, 80);
        check("draw_first_y", y, 60);
        check("draw_first_colour", colour, 6);
      end
    end
    check("draw_plot_count", pcnt, 4);

    // One move right.
    mv(1);
    check("move1_eg", endgame, 0);
    rd(0);
    check("move1_hx", x, 81);
    check("move1_hy", y, 60);
    check("move1_hcol", colour, 6);
    rd(3);
    check("move1_t3x", x, 78);
    check("move1_t3y", y, 60);
    rd(4);
    check("move1_len", plot, 0);

    // Reversal rejected, then turn up, then key with move.
    key(2);
    mv(1);
    rd(0);
    check("rev_hx", x, 82);
    check("rev_hy", y, 60);
    key(0);
    mv(1);
    rd(0);
    check("up_hx", x, 82);
    check("up_hy", y, 59);
    cyc(1, 1, 1, 0, 0, 0, 0, 0);
    mv(1);
    rd(0);
    check("keymove_hx", x, 83);
    check("keymove_hy", y, 58);

    // Run into the right wall.
    mv(76);
    rd(0);
    check("wall_pre_hx", x, 159);
    mv(1);
    check("wall_eg_hi", endgame, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("wall_eg_lo", endgame, 0);
    rd(0);
    check("wall_rst_hx", x, 80);
    check("wall_rst_hy", y, 60);
    rd(4);
    check("wall_rst_len", plot, 0);
    cyc(0, 0, 0, 1, 2, 0, 0, 0);
    check("wall_rst_fx", x, 120);
    check("wall_rst_fy", y, 60);

    // Eat the fruit at (120,60).
    mv(39);
    rd(0);
    check("eat_pre_hx", x, 119);
    mv(1);
    rd(0);
    check("eat_hx", x, 120);
    check("eat_hy", y, 60);
    rd(4);
    check("eat_len5", plot, 1);
    check("eat_t4x", x, 116);
    rd(5);
    check("eat_len_not6", plot, 0);
    cyc(0, 0, 0, 1, 2, 0, 0, 0);
    check("eat_fx_range", x < 160, 1);
    check("eat_fy_range", y < 120, 1);

    // Loop back onto own body, then draw pass finds it.
    key(0); mv(1);
    key(2); mv(1);
    key(3); mv(1);
    key(1); mv(1);
    egc = 0;
    for (int j = 99; j >= 0; j--) begin
      cyc(0, 0, 0, 1, 0, 0, 0, j);
      if (endgame) egc++;
      check("loop_eg", endgame, (99 - j) == 4);
    end
    check("loop_pulses", egc, 1);

    // Reset asserted together with a move.
    do_reset(1);
    rd(0);
    check("rstmv_hx", x, 80);
    check("rstmv_hy", y, 60);
    rd(4);
    check("rstmv_len", plot, 0);

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset(1'($urandom_range(0, 1)));
      end else begin
        r  = $urandom_range(0, 5);
        sl = (r < 3) ? 0 : (r == 3) ? 1 : (r == 4) ? 2
           : $urandom_range(3, 15);
        cyc($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 3), 1'($urandom_range(0, 1)), sl,
            $urandom_range(0, 159), $urandom_range(0, 119),
            $urandom_range(0, 99));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/snake_datapath.md
SNAKE_DATAPATH -- requirements
Module: snake_datapath

Interface
REQ-001 Parameters: MAX_LEN, default 100, segment storage depth; INIT_LEN, default 4, length after reset or endgame.
REQ-002 clock  in  1  system clock; all state updates on its rising edge.
REQ-003 resetn  in  1  reset, synchronous, active-low.
REQ-004 move  in  1  one-cycle pulse: advance snake one cell.
REQ-005 keyboard  in  1  direction key valid this cycle.
REQ-006 keyboard_arrow  in  2  direction code: 0 up, 1 right, 2 left, 3 down.
REQ-007 output_signal  in  1  plot request from controller.
REQ-008 select  in  4  pixel source: 0 snake segment, 1 erase, 2 fruit, any other value owned by other blocks.
REQ-009 counter_x / counter_y  in  8 / 7  erase raster position.
REQ-010 counter_j  in  7  draw countdown, 99..0; segment index = 99 - counter_j.
REQ-011 x / y  out  8 / 7  registered plot coordinate.
REQ-012 colour  out  3  registered plot colour.
REQ-013 plot  out  1  registered VGA write enable.
REQ-014 endgame  out  1  one-cycle registered pulse: game lost.

Function
REQ-015 Playfield SHALL be 160x120 cells, 1 pixel per cell; legal x 0..159, y 0..119.
REQ-016 State SHALL comprise seg_x[0..MAX_LEN-1], seg_y[0..MAX_LEN-1] (seg 0 = head), len (7 bits), dir (2 bits), pend_dir (2 bits), fruit_x, fruit_y, lfsr (16 bits).
REQ-017 Initial game state: len=INIT_LEN, dir=pend_dir=1 (right), seg k=(80-k, 60) for k=0..INIT_LEN-1, fruit=(120,60), lfsr=16'hACE1.
REQ-018 lfsr SHALL shift every clock: Fibonacci, taps 16,14,13,11, free-running, never reinitialised except by resetn.
REQ-019 When keyboard=1, pend_dir SHALL load keyboard_arrow unless (keyboard_arrow XOR dir)==3 (reversal), which is ignored.
REQ-020 On move: dir<=pend_dir; next head = seg 0 + delta(pend_dir); up y-1, down y+1, left x-1, right x+1.
REQ-021 Move with next head outside the legal range (x>159, y>119, or underflow below 0) SHALL NOT shift; instead endgame pulses next cycle and initial game state (REQ-017) loads, except lfsr.
REQ-022 Legal move: seg[i]<=seg[i-1] for i=1..MAX_LEN-1, seg[0]<=next head.
REQ-023 Legal move with next head == fruit: len<=len+1, saturating at MAX_LEN; fruit relocates to candidate from lfsr.
REQ-024 Fruit candidate: fx=lfsr[7:0], minus 128 if >=160; fy=lfsr[14:8], minus 64 if >=120.
REQ-025 Plot outputs SHALL have 1-cycle latency from output_signal/select/counters; plot=0 when output_signal=0.
REQ-026 select=1: x=counter_x, y=counter_y, colour=3'b000, plot=1.
REQ-027 select=2: x=fruit_x, y=fruit_y, colour=3'b100, plot=1.
REQ-028 select=0, idx=99-counter_j: if idx<len, x,y=seg[idx], colour=3'b110 for idx 0 else 3'b010, plot=1; idx>=len gives plot=0.
REQ-029 Other select values SHALL give plot=0; x, y, colour hold.
REQ-030 Self-collision: select=0 with output_signal=1, 1<=idx<len and seg[idx]==seg[0] SHALL pulse endgame next cycle and load initial game state.
REQ-031 move and plot request in the same cycle: plot uses pre-move state; move applies.
REQ-032 keyboard and move in the same cycle: move uses prior pend_dir; the new key is checked against the updated dir.
REQ-033 endgame SHALL never exceed one cycle; simultaneous wall and self-collision give a single pulse.

Reset
REQ-034 resetn=0 on clock edge: initial game state plus lfsr=16'hACE1; x=0, y=0, colour=0, plot=0, endgame=0.
REQ-035 Reset mid-move or mid-draw SHALL abandon the operation with no partial shift.

Verification
REQ-036 Reset, one move -> head (81,60), seg3 (78,60), len 4, endgame 0.
REQ-037 dir right, key left, move -> key rejected, head x+1; key up, move -> head y-1.
REQ-038 Place head at (119,60) heading right, move -> head (120,60), len 5, fruit at lfsr candidate within 0..159/0..119.
REQ-039 Head (159,10) heading right, move -> endgame high exactly 1 cycle, state back to REQ-017 values.
REQ-040 Draw pass, counter_j 99..0 with len 4 -> exactly 4 plot pulses, first colour 110 at (80,60); idx 4..99 plot 0.
REQ-041 Drive a loop of moves (up, left, down, right) with len>=5, then a draw pass -> endgame pulse on the colliding index cycle+1.
